// File: rtl/cmp_pkg.sv
// Shared types and helpers for the iterative magnitude comparator.
//   state_t        : controller states
//   LT / EQ / GT   : result encodings, packed as {less, equal, greater}
//   calc_nslice()  : number of CHUNK-bit slices in a WIDTH-bit operand
//   slicing_ok()   : configuration check, WIDTH must be a multiple of CHUNK
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    function automatic int unsigned calc_nslice(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    function automatic bit slicing_ok(input int unsigned width,
                                      input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_comparator_if.sv
// Operand/result handshake bundle for seq_comparator.
//   master : upstream producer / result consumer side
//   slave  : comparator side
//   in_valid/in_ready with x, y, is_signed carry the operands;
//   out_valid/out_ready with less, equal, greater carry the result.
interface seq_comparator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             less;
    logic             equal;
    logic             greater;

    modport master (
        output in_valid, x, y, is_signed, out_ready,
        input  in_ready, out_valid, less, equal, greater
    );

    modport slave (
        input  in_valid, x, y, is_signed, out_ready,
        output in_ready, out_valid, less, equal, greater
    );
endinterface

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   a, b     : slice operands
//   slice_lt : a < b,  slice_eq : a == b,  slice_gt : a > b
module cmp_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             slice_lt,
    output logic             slice_eq,
    output logic             slice_gt
);

    always_comb begin
        slice_lt = (a < b);
        slice_eq = (a == b);
        slice_gt = (a > b);
    end

endmodule

// File: rtl/seq_comparator.sv
// Iterative WIDTH-bit magnitude comparator, one CHUNK-bit slice per clock,
// most significant slice first, with optional early exit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_comparator_if slave (operands in, result out)
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHUNK      = 4,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_comparator_if.slave bus
);

    localparam int unsigned NSLICE   = calc_nslice(WIDTH, CHUNK);
    localparam int unsigned KW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0]    KTOP     = KW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    if (!slicing_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("seq_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xa_q, ya_q;
    logic [KW-1:0]    k_q;
    logic             lt_q, gt_q;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       res_q, res_d;

    logic [CHUNK-1:0] xs, ys;
    logic             s_lt, s_eq, s_gt;
    logic             accept, decided, lt_n, gt_n;

    // Current slice of the (biased) operands
    assign xs = CHUNK'(xa_q >> (32'(k_q) * CHUNK));
    assign ys = CHUNK'(ya_q >> (32'(k_q) * CHUNK));

    cmp_slice #(.CHUNK(CHUNK)) u_slice (
        .a        (xs),
        .b        (ys),
        .slice_lt (s_lt),
        .slice_eq (s_eq),
        .slice_gt (s_gt)
    );

    assign accept  = in_ready_q && bus.in_valid;
    // Only the first differing slice may set the sticky decision
    assign decided = lt_q || gt_q;
    assign lt_n    = lt_q || (!decided && s_lt);
    assign gt_n    = gt_q || (!decided && s_gt);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: if ((EARLY_EXIT && !decided && !s_eq) || (k_q == '0)) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        res_d       = res_q;
        if (accept) begin
            res_d = '0;
        end else if ((state_q == SCAN) && (state_d == DONE)) begin
            res_d = lt_n ? LT : (gt_n ? GT : EQ);
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    // Operand capture (MSB bias turns signed compare into unsigned),
    // slice index and sticky decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa_q <= '0;
            ya_q <= '0;
            k_q  <= '0;
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (accept) begin
            xa_q <= bus.x ^ (bus.is_signed ? SIGN_BIT : '0);
            ya_q <= bus.y ^ (bus.is_signed ? SIGN_BIT : '0);
            k_q  <= KTOP;
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (state_q == SCAN) begin
            lt_q <= lt_n;
            gt_q <= gt_n;
            if (k_q != '0) begin
                k_q <= k_q - KW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.less      = res_q[2];
    assign bus.equal     = res_q[1];
    assign bus.greater   = res_q[0];

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, iterative magnitude comparator for the single-cycle datapath. It compares two WIDTH-bit operands in CHUNK-bit slices, most significant slice first, one slice per clock. It supports signed and unsigned modes, and an early exit on the first differing slice. Operands enter and results leave through valid/ready handshakes, so the branch/compare logic can stall on it.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; NSLICE = WIDTH/CHUNK is derived, not a parameter.
- EARLY_EXIT, 1, 1 = finish on first differing slice; 0 = always scan all NSLICE slices (constant latency).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept operands
- x  in  WIDTH  left operand
- y  in  WIDTH  right operand
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- less  out  1  x < y
- equal  out  1  x == y
- greater  out  1  x > y

## Operation
- **States:** IDLE, SCAN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready: latch x, y, is_signed; slice index k=NSLICE-1; go SCAN.
- **Signed mode:** the MSB of both latched operands is inverted at capture; the unsigned compare then runs on the biased values. The result is overflow-free: 0x7FFF > 0x8000 signed.
- **SCAN**, each cycle compares slice k of the latched operands:
  - Slice differs and no decision yet: record lt/gt (sticky). With EARLY_EXIT=1, go DONE.
  - Slice equal and k==0: go DONE. equal=1 if no decision was recorded.
  - Otherwise k decrements.
  - EARLY_EXIT=0: always go DONE after k==0. The result is taken from the first differing slice.
- **DONE**
  - out_valid=1. less/equal/greater are registered and stable.
  - On out_ready, go IDLE.
- **Outputs**
  - Exactly one of less/equal/greater is high whenever out_valid=1.
  - Results hold after the handshake until the next acceptance clears them.
- in_ready=0 in SCAN and DONE: one operation in flight, no overlap.
- in_valid in SCAN/DONE is ignored; the upstream must hold it.

## Timing
- **Reset values:** state=IDLE, out_valid=0, less=equal=greater=0, in_ready=0 while rst is high, in_ready=1 on the first cycle after deassertion.
- **Latency:** operands accepted at edge t; out_valid rises at edge t+m.
  - EARLY_EXIT=1: m = 1 + number of equal slices above the first differing slice; m = NSLICE if x==y.
  - EARLY_EXIT=0: m = NSLICE always.
- WIDTH==CHUNK gives m=1 in both modes.
- **Result handshake:** completes on the edge where out_valid && out_ready. The next acceptance can occur one cycle later, since in_ready rises in IDLE.
- **Reset mid-operation:** returns to IDLE immediately; the partial result is discarded and no out_valid pulse occurs.
- **Back-pressure:** out_ready low keeps DONE and all result outputs constant indefinitely.

## Structure
- Package cmp_pkg:
  - state enum (IDLE, SCAN, DONE);
  - result encoding constants (LT, EQ, GT);
  - function to compute NSLICE;
  - elaboration check that WIDTH % CHUNK == 0.
- Sub-module cmp_slice: combinational CHUNK-bit unsigned compare producing slice_lt, slice_eq, slice_gt.
- Top level holds the FSM, operand registers, slice index counter and sticky result register.

## Test plan
- **Unsigned vs signed:** WIDTH=16, CHUNK=4.
  - x=0x8000, y=0x0001, is_signed=0 -> greater=1.
  - Same operands, is_signed=1 -> less=1.
- **Signed overflow case:** x=0x7FFF, y=0x8000, is_signed=1 -> greater=1, equal=0, less=0.
- **Early exit latency:** EARLY_EXIT=1.
  - x=0x1234, y=0x0234 -> out_valid 1 cycle after acceptance, greater=1.
  - x=0xBEEF, y=0xBEEF -> 4 cycles, equal=1.
  - EARLY_EXIT=0, x=0x1234, y=0x0234 -> 4 cycles.
- **Back-pressure:** hold out_ready=0 for 5 cycles in DONE -> out_valid and the result are unchanged, in_ready=0. Then pulse out_ready -> in_ready=1 next cycle.
- **Reset mid-scan:** x=0x0001, y=0x0002; assert rst 1 cycle after acceptance -> out_valid never rises, all outputs 0, in_ready=1 after release.
- **Degenerate width:** WIDTH=8, CHUNK=8, x=0xFF, y=0x01 unsigned -> greater=1 with latency 1.
